// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - digit codes, segment patterns and FSM states shared by the display stage
package sseg_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hA;
  localparam logic [3:0] DIG_DASH  = 4'hB;

  // Active-low {dp,g,f,e,d,c,b,a}; dp stays dark
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_FORMAT = 2'd2
  } state_t;

  function automatic logic [7:0] seg_pattern(input logic [3:0] code);
    case (code)
      4'd0:     seg_pattern = SEG_0;
      4'd1:     seg_pattern = SEG_1;
      4'd2:     seg_pattern = SEG_2;
      4'd3:     seg_pattern = SEG_3;
      4'd4:     seg_pattern = SEG_4;
      4'd5:     seg_pattern = SEG_5;
      4'd6:     seg_pattern = SEG_6;
      4'd7:     seg_pattern = SEG_7;
      4'd8:     seg_pattern = SEG_8;
      4'd9:     seg_pattern = SEG_9;
      DIG_DASH: seg_pattern = SEG_DASH;
      default:  seg_pattern = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 17-bit sequential double-dabble, one shift per cycle, five BCD digits out
module bin2bcd_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [16:0] bin_i,
  output logic [19:0] bcd_o,
  output logic        done_o
);

  localparam logic [4:0] N_SHIFT = 5'd17;

  logic [36:0] sh_q, sh_d, adj;
  logic [4:0]  cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    adj   = sh_q;
    if (start_i) begin
      sh_d  = {20'd0, bin_i};
      cnt_d = N_SHIFT;
    end else if (cnt_q != 5'd0) begin
      for (int i = 0; i < 5; i++) begin
        if (adj[17 + 4*i +: 4] >= 4'd5) adj[17 + 4*i +: 4] = adj[17 + 4*i +: 4] + 4'd3;
      end
      sh_d  = adj << 1;
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o  = sh_q[36:17];
  // Flags the final shift so the caller can consume bcd_o on the very next cycle
  assign done_o = (cnt_q == 5'd1);

endmodule

// File: rtl/fxp_sseg_display.sv
// rtl/fxp_sseg_display.sv - Q16.16 to four-digit multiplexed seven-segment display stage
module fxp_sseg_display
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] value,
  input  logic        load,
  output logic        ready,
  output logic [7:0]  sseg,
  output logic [3:0]  DISP_EN
);

  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  state_t        state_q, state_d;
  logic          sign_q, sign_d;
  logic [3:0]    dig_q [4];
  logic [3:0]    dig_d [4];
  logic [3:0]    fmt   [4];
  logic [32:0]   mag;
  logic [16:0]   int_in;
  logic          conv_start, conv_done, neg, ovf;
  logic [19:0]   bcd;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [7:0]    sseg_q;
  logic [3:0]    en_q;

  // 33-bit magnitude so 0x80000000 yields 32768 instead of wrapping
  assign mag    = value[31] ? (33'd0 - {1'b1, value}) : {1'b0, value};
  assign int_in = 17'(mag >> 16);

  bin2bcd_seq u_bcd (
    .clk_i   (CLOCK),
    .rst_i   (RESET),
    .start_i (conv_start),
    .bin_i   (int_in),
    .bcd_o   (bcd),
    .done_o  (conv_done)
  );

  always_comb begin
    neg    = sign_q && (bcd != 20'd0);
    ovf    = neg ? (bcd[19:12] != 8'd0) : (bcd[19:16] != 4'd0);
    fmt[0] = bcd[3:0];
    fmt[1] = (bcd[19:4]  != 16'd0) ? bcd[7:4]   : DIG_BLANK;
    fmt[2] = (bcd[19:8]  != 12'd0) ? bcd[11:8]  : DIG_BLANK;
    fmt[3] = neg ? DIG_DASH : ((bcd[19:12] != 8'd0) ? bcd[15:12] : DIG_BLANK);
    if (ovf) begin
      for (int i = 0; i < 4; i++) fmt[i] = DIG_DASH;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    conv_start = 1'b0;
    dig_d      = dig_q;
    case (state_q)
      ST_IDLE: if (load) begin
        sign_d     = value[31];
        conv_start = 1'b1;
        state_d    = ST_CONV;
      end
      ST_CONV: if (conv_done) state_d = ST_FORMAT;
      ST_FORMAT: begin
        dig_d   = fmt;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= DIG_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      sseg_q  <= SEG_BLANK;
      en_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
      en_q    <= ~(4'b0001 << idx_q);
      sseg_q  <= seg_pattern(dig_q[idx_q]);
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign sseg    = sseg_q;
  assign DISP_EN = en_q;

endmodule

// File: tb/tb_fxp_sseg_display.sv
// tb/tb_fxp_sseg_display.sv - self-checking bench for fxp_sseg_display with a slot-level display model
module tb_fxp_sseg_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld;
  logic [31:0] val;
  logic        rdy;
  logic [7:0]  seg;
  logic [3:0]  en;

  int n_tests = 0;
  int n_fail  = 0;

  fxp_sseg_display #(.REFRESH_DIV(4)) dut (
    .CLOCK   (clk),
    .RESET   (rst),
    .value   (val),
    .load    (ld),
    .ready   (rdy),
    .sseg    (seg),
    .DISP_EN (en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int d);
    logic [7:0] t [10];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[d];
  endfunction

  // Expected patterns {slot3,slot2,slot1,slot0} for a Q16.16 value
  function automatic logic [31:0] expect_slots(input logic [31:0] v);
    longint sv, m;
    int ip, pw;
    bit neg;
    logic [31:0] r;
    sv  = longint'($signed(v));
    m   = (sv < 0) ? -sv : sv;
    ip  = int'(m / 65536);
    neg = v[31] && (ip != 0);
    if (neg ? (ip > 999) : (ip > 9999)) return {4{8'hBF}};
    pw = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && neg)           r[8*k +: 8] = 8'hBF;
      else if (k == 0 || ip >= pw) r[8*k +: 8] = pat((ip / pw) % 10);
      else                         r[8*k +: 8] = 8'hFF;
      pw = pw * 10;
    end
    return r;
  endfunction

  logic [7:0]  m_seg;
  logic [3:0]  m_en;
  logic [31:0] m_shown, m_next;
  int          m_busy, m_n, m_slot;
  bit          m_valid = 1'b0;
  logic        m_ready;

  assign m_ready = (m_busy == 0);

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_busy  = 0;
      m_n     = 0;
      m_shown = {4{8'hFF}};
      m_seg   = 8'hFF;
      m_en    = 4'hF;
    end else if (m_valid) begin
      m_slot = (m_n / 4) % 4;
      m_en   = ~(4'b0001 << m_slot);
      m_seg  = m_shown[8*m_slot +: 8];
      m_n++;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_shown = m_next;
      end else if (ld) begin
        m_busy = 18;
        m_next = expect_slots(val);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_ready",  {31'd0, rdy}, {31'd0, m_ready});
      chk("model_disp_en", {28'd0, en}, {28'd0, m_en});
      chk("model_sseg",   {24'd0, seg}, {24'd0, m_seg});
    end
  end

  task automatic load_and_wait(input logic [31:0] v);
    int n;
    @(negedge clk);
    val = v;
    ld  = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    n  = 0;
    while (!rdy && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("latency", n, 18);
  endtask

  task automatic check_slots(input string name, input logic [31:0] exp);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      case (en)
        4'hE:    chk(name, {24'd0, seg}, {24'd0, exp[7:0]});
        4'hD:    chk(name, {24'd0, seg}, {24'd0, exp[15:8]});
        4'hB:    chk(name, {24'd0, seg}, {24'd0, exp[23:16]});
        4'h7:    chk(name, {24'd0, seg}, {24'd0, exp[31:24]});
        default: chk({name, "_en"}, {28'd0, en}, 32'hE);
      endcase
    end
  endtask

  logic [3:0] en_seq [4];

  initial begin
    int n;
    en_seq = '{4'hE, 4'hD, 4'hB, 4'h7};
    rst = 1'b1;
    ld  = 1'b0;
    val = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready",   {31'd0, rdy}, 32'd1);
    chk("rst_disp_en", {28'd0, en},  32'hF);
    chk("rst_sseg",    {24'd0, seg}, 32'hFF);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("scan_en",   {28'd0, en},  {28'd0, en_seq[k/4]});
      chk("scan_sseg", {24'd0, seg}, 32'hFF);
    end

    load_and_wait(32'h0001_8000);
    check_slots("one_point_five", 32'hFFFF_FFF9);
    load_and_wait(32'hFFF3_0000);
    check_slots("minus_13", 32'hBFFF_F9B0);
    load_and_wait(32'h270F_0000);
    check_slots("pos_9999", 32'h9090_9090);
    load_and_wait(32'h2710_0000);
    check_slots("pos_10000", 32'hBFBF_BFBF);
    load_and_wait(32'hFC19_0000);
    check_slots("minus_999", 32'hBF90_9090);
    load_and_wait(32'hFC18_0000);
    check_slots("minus_1000", 32'hBFBF_BFBF);
    load_and_wait(32'h8000_0000);
    check_slots("most_negative", 32'hBFBF_BFBF);
    load_and_wait(32'hFFFF_8000);
    check_slots("minus_half", 32'hFFFF_FFC0);
    load_and_wait(32'h0000_0000);
    check_slots("zero", 32'hFFFF_FFC0);

    @(negedge clk);
    val = 32'h0005_0000;
    ld  = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (4) @(negedge clk);
    val = 32'h0007_0000;
    ld  = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    n  = 0;
    while (!rdy && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("ignored_load_latency", n, 13);
    check_slots("ignored_load", 32'hFFFF_FF92);

    @(negedge clk);
    val = 32'h0009_0000;
    ld  = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    val = 32'h0003_0000;
    ld  = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, rdy}, 32'd1);
    rst = 1'b0;
    ld  = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", {31'd0, rdy}, 32'd1);
    check_slots("abort_blank", 32'hFFFF_FFFF);
    load_and_wait(32'h0002_0000);
    check_slots("after_abort", 32'hFFFF_FFA4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fxp_sseg_display.md
# fxp_sseg_display

Downstream display stage for the RK4 core on the Basys 3 board. It accepts a signed Q16.16 result through a load/ready handshake and converts the truncated integer part to BCD with a sequential double-dabble. It then drives the four-digit, common-anode seven-segment display with a time-multiplexed scan. The block feeds the top-level `sseg` and `DISP_EN` pins.

## Interface
- REFRESH_DIV, 100000, CLOCK cycles per digit slot (100 MHz → 1 kHz per digit).
- CLOCK  in  1  system clock, rising-edge.
- RESET  in  1  synchronous, active-high reset.
- value  in  32  signed Q16.16 result from the RK4 core.
- load  in  1  single-cycle strobe; sampled only while ready=1.
- ready  out  1  high when idle and able to accept a load.
- sseg  out  8  {dp,g,f,e,d,c,b,a}, active-low; dp is always 1.
- DISP_EN  out  4  anode enables, active-low; bit 0 is the rightmost digit.

## Operation
- Digit code is 4 bits: 0–9 are decimal, 0xA is blank, 0xB is dash (segment g only).
- Segment patterns: 0→0xC0, 1→0xF9, 3→0xB0, 9→0x90, blank→0xFF, dash→0xBF.
- FSM states:
  - IDLE: ready=1. On load, capture sign=value[31] and mag=|value| (32-bit two's complement), keep int=mag[31:16], go to CONV.
  - CONV: one double-dabble shift of the 17-bit int field per cycle, for 17 cycles, giving 5 BCD digits. Then go to FORMAT.
  - FORMAT: write the 4 display digit registers, go to IDLE.
- A load seen while not in IDLE is ignored. No queueing.
- int is mag[31:16] of a 33-bit magnitude, so 0x80000000 gives int=32768 and is handled as overflow.
- Format rules:
  - neg = sign and int≠0. −0.5 therefore displays as "   0".
  - Overflow: all four digits are dash. Overflow means (neg and int>999) or (!neg and int>9999).
  - Positive: 4 digits, with leading zeros blanked. The units digit is always shown.
  - Negative: digit3 is dash, digits 2..0 are the magnitude with leading zeros blanked.
- Scan:
  - A refresh counter runs 0..REFRESH_DIV−1.
  - On wrap, the digit index advances 0→1→2→3→0.
  - DISP_EN = ~(1<<idx), and sseg shows the pattern for digit idx.
- Reset mid-conversion aborts the conversion, returns to IDLE, and blanks all digits.

## Timing
- Reset values:
  - ready=1, DISP_EN=4'b1111, sseg=8'hFF.
  - Digit registers are blank, idx=0, counter=0.
- On the first cycle after reset, scanning resumes with blank patterns.
- Load accepted at edge t:
  - ready=0 from t.
  - Shift cycles occur at edges t+1..t+17.
  - FORMAT runs at edge t+18, where the digit registers update and ready=1.
  - Latency is 18 cycles. Back-to-back loads are possible every 19 cycles.
- The displayed digits never show a partial result. All four digits change atomically at FORMAT.
- sseg and DISP_EN are registered and lag the idx change by 1 cycle. Both outputs change on the same edge.
- Load arriving during reset is ignored. Reset has priority.

## Structure
- Shared package sseg_pkg holds:
  - digit-code constants (DIG_BLANK=4'hA, DIG_DASH=4'hB);
  - the 8-bit segment pattern constants;
  - the FSM state enum values.
- Sub-module bin2bcd_seq:
  - A 17-bit sequential double-dabble with start/done.
  - Owns the shift register, add-3 logic and iteration counter.
- The top block keeps the handshake FSM, format logic and scan mux.

## Test plan
Bench uses REFRESH_DIV=4.
1. Hold RESET 3 cycles → ready=1, DISP_EN=1111, sseg=FF. After release, DISP_EN cycles 1110→1101→1011→0111 every 4 cycles with sseg=FF.
2. value=0x0001_8000 (1.5), load → ready=0 for 18 cycles, then 1. When DISP_EN=1110, sseg=F9; the other three slots show FF.
3. value=0xFFF3_0000 (−13) → slots show 0 (1110)=B0, 1 (1101)=F9, 2 (1011)=FF, 3 (0111)=BF.
4. Overflow and boundary values:
   - 0x270F_0000 (9999) → "9999" (all 90).
   - 0x2710_0000 (10000) → all BF.
   - 0xFC18_0000 (−1000) → all BF.
   - 0x8000_0000 → all BF.
5. Zero handling: value 0xFFFF_8000 (−0.5) and 0x0000_0000 → digit0=C0, other slots FF, no dash.
6. Handshake and reset:
   - Load 0x0005_0000. Pulse load with 0x0007_0000 at t+5 → display is 5, and the second load is ignored.
   - Load 0x0009_0000, then assert RESET at t+8 → ready=1 and all slots FF. A new load of 0x0002_0000 afterwards displays 2.
